axis_step_sequencer: RTL and testbench

- Per-axis motion sequencer sitting directly upstream of the stepper phase controller.
- Accepts move and home commands over a valid/ready handshake and emits a one-cycle step strobe plus direction at a commanded rate.
- Debounces the raw limit switch, tracks signed absolute position, and runs a seek-then-backoff homing sequence.
- One instance per axis (X, Y, Z) in the top level; step_pulse/step_dir drive the phase sequencer.

---
 rtl/axis_step_sequencer_if.sv | 22 ++
 rtl/axis_step_sequencer.sv | 169 ++++++++++++++++
 tb/tb_axis_step_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_step_sequencer_if.sv
// Command channel for axis_step_sequencer: move/home request with valid/ready handshake.
interface axis_step_sequencer_if #(
    parameter int unsigned POS_W = 24,
    parameter int unsigned PER_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_home;
    logic             cmd_dir;
    logic [POS_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_home, cmd_dir, cmd_steps, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_home, cmd_dir, cmd_steps, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/axis_step_sequencer.sv
// Per-axis step sequencer: timed move, seek-then-backoff homing, debounced limit switch.
// Optional software travel bounds when AXIS_SOFT_LIMIT_EN is defined.
module axis_step_sequencer #(
    parameter int unsigned POS_W         = 24,
    parameter int unsigned PER_W         = 32,
    parameter int unsigned MIN_PERIOD    = 16,
    parameter int unsigned DEBOUNCE_CYC  = 50000,
    parameter int unsigned HOME_PERIOD   = 50000,
    parameter int unsigned BACKOFF_STEPS = 64
`ifdef AXIS_SOFT_LIMIT_EN
    ,
    parameter int          SOFT_MAX      = 8000000
`endif
) (
    input  logic                    osc_clk,
    input  logic                    rstn,
    axis_step_sequencer_if.slave    cmd_if,
    input  logic                    stop,
    input  logic                    limit_raw,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic                    homed,
    output logic                    limit_db,
    output logic signed [POS_W-1:0] position
);
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [PER_W-1:0] MinPer = PER_W'(MIN_PERIOD);

    typedef enum logic [1:0] {StIdle, StMove, StSeek, StBackoff} state_e;

    state_e                  state;
    logic                    lim_s1, lim_s2;
    logic [DbW-1:0]          db_cnt;
    logic [PER_W-1:0]        per_cnt, period;
    logic [POS_W-1:0]        remaining;
    logic                    step_due;
    logic                    soft_block;
    logic signed [POS_W-1:0] pos_next;

    assign cmd_if.cmd_ready = (state == StIdle);
    assign busy             = (state != StIdle);
    assign step_due         = (per_cnt == period - 1'b1);
    assign pos_next         = step_dir ? position + POS_W'(1) : position - POS_W'(1);

`ifdef AXIS_SOFT_LIMIT_EN
    localparam logic signed [POS_W-1:0] SoftMax = POS_W'(SOFT_MAX);
    assign soft_block = homed && (step_dir ? (position >= SoftMax)
                                           : (position[POS_W-1] || position == '0));
`else
    assign soft_block = 1'b0;
`endif

    // Level only flips after DEBOUNCE_CYC consecutive samples disagreeing with it.
    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            lim_s1   <= 1'b0;
            lim_s2   <= 1'b0;
            db_cnt   <= '0;
            limit_db <= 1'b0;
        end else begin
            lim_s1 <= limit_raw;
            lim_s2 <= lim_s1;
            if (lim_s2 == limit_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DbW'(DEBOUNCE_CYC - 1)) begin
                limit_db <= lim_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            step_pulse <= 1'b0;
            step_dir   <= 1'b1;
            done       <= 1'b0;
            fault      <= 1'b0;
            homed      <= 1'b0;
            position   <= '0;
            per_cnt    <= '0;
            period     <= '0;
            remaining  <= '0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            per_cnt    <= step_due ? '0 : per_cnt + 1'b1;
            unique case (state)
                StIdle: begin
                    per_cnt <= '0;
                    if (cmd_if.cmd_valid) begin
                        if (cmd_if.cmd_home) begin
                            state    <= StSeek;
                            step_dir <= 1'b0;
                            period   <= PER_W'(HOME_PERIOD);
                            fault    <= 1'b0;
                            homed    <= 1'b0;
                        end else if (cmd_if.cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= StMove;
                            step_dir  <= cmd_if.cmd_dir;
                            remaining <= cmd_if.cmd_steps;
                            period    <= (cmd_if.cmd_period < MinPer) ? MinPer
                                                                      : cmd_if.cmd_period;
                        end
                    end
                end
                StMove: begin
                    if (stop) begin
                        state <= StIdle;
                    end else if (limit_db && !step_dir) begin
                        fault <= 1'b1;
                        state <= StIdle;
                    end else if (step_due) begin
                        if (soft_block) begin
                            fault <= 1'b1;
                            state <= StIdle;
                        end else begin
                            step_pulse <= 1'b1;
                            position   <= pos_next;
                            remaining  <= remaining - 1'b1;
                            if (remaining == POS_W'(1)) begin
                                state <= StIdle;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                StSeek: begin
                    if (stop) begin
                        state <= StIdle;
                    end else if (limit_db) begin
                        // Switch reached: drop the pending seek step, restart timing for backoff.
                        state     <= StBackoff;
                        step_dir  <= 1'b1;
                        per_cnt   <= '0;
                        remaining <= POS_W'(BACKOFF_STEPS);
                    end else if (step_due) begin
                        step_pulse <= 1'b1;
                        position   <= pos_next;
                    end
                end
                StBackoff: begin
                    if (stop) begin
                        state <= StIdle;
                    end else if (step_due) begin
                        step_pulse <= 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == POS_W'(1)) begin
                            position <= '0;
                            homed    <= 1'b1;
                            done     <= 1'b1;
                            state    <= StIdle;
                        end else begin
                            position <= pos_next;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_step_sequencer.sv
// Scoreboard bench for axis_step_sequencer with shortened debounce and homing periods.
module tb_axis_step_sequencer;
    localparam int unsigned POS_W  = 24;
    localparam int unsigned PER_W  = 32;
    localparam int          MIN_P  = 16;
    localparam int          DB     = 8;
    localparam int          HOME_P = 16;
    localparam int          BACK   = 64;

    logic                    osc_clk = 1'b0;
    logic                    rstn    = 1'b1;
    logic                    stop    = 1'b0;
    logic                    limit_raw = 1'b0;
    logic                    step_pulse, step_dir, busy, done, fault, homed, limit_db;
    logic signed [POS_W-1:0] position;

    axis_step_sequencer_if #(.POS_W(POS_W), .PER_W(PER_W)) cmd_if ();

    axis_step_sequencer #(
        .POS_W        (POS_W),
        .PER_W        (PER_W),
        .MIN_PERIOD   (MIN_P),
        .DEBOUNCE_CYC (DB),
        .HOME_PERIOD  (HOME_P),
        .BACKOFF_STEPS(BACK)
`ifdef AXIS_SOFT_LIMIT_EN
        ,
        .SOFT_MAX     (10)
`endif
    ) dut (
        .osc_clk   (osc_clk),
        .rstn      (rstn),
        .cmd_if    (cmd_if),
        .stop      (stop),
        .limit_raw (limit_raw),
        .step_pulse(step_pulse),
        .step_dir  (step_dir),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .homed     (homed),
        .limit_db  (limit_db),
        .position  (position)
    );

    always #5 osc_clk = ~osc_clk;

    int cyc = 0;
    always @(posedge osc_clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic dir;
        int   pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;
    int   done_cnt  = 0;
    int   done_cyc  = -1;
    int   exp_pos   = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pops one expected step per observed strobe and checks its timing, direction and position.
    always @(negedge osc_clk) begin
        if (step_pulse) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_pulse", cyc, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cyc", cyc, mon_e.cyc);
                check("pulse_dir", step_dir, mon_e.dir);
                check("pulse_pos", longint'(position), mon_e.pos);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic issue(input logic home, input logic dir, input int steps, input int period,
                         output int acc);
        @(negedge osc_clk);
        check("ready_before_cmd", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_home   = home;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_steps  = POS_W'(steps);
        cmd_if.cmd_period = PER_W'(period);
        @(posedge osc_clk);
        #1 acc = cyc;
        @(negedge osc_clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic push_steps(input int acc, input int eff, input int n, input logic dir);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            exp_pos += dir ? 1 : -1;
            e.cyc = acc + eff * k;
            e.dir = dir;
            e.pos = exp_pos;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge osc_clk);
            n++;
        end
        check(tag, busy, 0);
        @(negedge osc_clk);
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(negedge osc_clk);
            t++;
            if (step_pulse) got++;
        end
        check(tag, got, n);
    endtask

    int acc;
    int r;
    int pc;
    int bk_start;

    initial begin
        exp_t e;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_home   = 1'b0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_period = '0;
        #2 rstn = 1'b0;
        repeat (3) @(negedge osc_clk);
        check("rst_step_pulse", step_pulse, 0);
        check("rst_step_dir", step_dir, 1);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_homed", homed, 0);
        check("rst_limit_db", limit_db, 0);
        check("rst_position", longint'(position), 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;
        @(negedge osc_clk);
        check("ready_after_rst", cmd_if.cmd_ready, 1);

        // Forward move, 5 steps at 20 clocks.
        issue(1'b0, 1'b1, 5, 20, acc);
        push_steps(acc, 20, 5, 1'b1);
        wait_idle("mv1_idle", 300);
        check("mv1_pos", longint'(position), 5);
        check("mv1_done_cnt", done_cnt, 1);
        check("mv1_done_cyc", done_cyc, acc + 100);
        check("mv1_ready", cmd_if.cmd_ready, 1);
        check("mv1_queue", exp_q.size(), 0);

        // Period below minimum is clamped.
        issue(1'b0, 1'b0, 4, 3, acc);
        push_steps(acc, MIN_P, 4, 1'b0);
        wait_idle("mv2_idle", 300);
        check("mv2_pos", longint'(position), 1);
        check("mv2_done_cnt", done_cnt, 2);
        check("mv2_queue", exp_q.size(), 0);

        // Limit glitch one sample short of the debounce window is ignored.
        issue(1'b0, 1'b0, 4, 40, acc);
        push_steps(acc, 40, 4, 1'b0);
        repeat (5) @(negedge osc_clk);
        limit_raw = 1'b1;
        repeat (DB - 1) @(negedge osc_clk);
        limit_raw = 1'b0;
        wait_idle("glitch_idle", 400);
        check("glitch_fault", fault, 0);
        check("glitch_limit_db", limit_db, 0);
        check("glitch_done_cnt", done_cnt, 3);
        check("glitch_pos", longint'(position), -3);
        check("glitch_queue", exp_q.size(), 0);

        // Sustained limit during a reverse move faults before the next step.
        issue(1'b0, 1'b0, 10, 20, acc);
        push_steps(acc, 20, 2, 1'b0);
        wait_pulses("flt_two_pulses", 2, 100);
        limit_raw = 1'b1;
        repeat (DB + 1) @(negedge osc_clk);
        check("flt_db_low", limit_db, 0);
        @(negedge osc_clk);
        check("flt_db_high", limit_db, 1);
        check("flt_fault_not_yet", fault, 0);
        @(negedge osc_clk);
        check("flt_fault", fault, 1);
        check("flt_busy", busy, 0);
        repeat (40) @(negedge osc_clk);
        check("flt_done_cnt", done_cnt, 3);
        check("flt_pos", longint'(position), -5);
        check("flt_queue", exp_q.size(), 0);
        limit_raw = 1'b0;
        repeat (DB + 4) @(negedge osc_clk);
        check("flt_db_release", limit_db, 0);

        // Homing: 10 seek steps, switch closes, 64 backoff steps, position zeroed.
        issue(1'b1, 1'b0, 0, 0, acc);
        push_steps(acc, HOME_P, 10, 1'b0);
        wait_pulses("home_seek_pulses", 10, 400);
        r = cyc;
        limit_raw = 1'b1;
        bk_start = r + DB + 3;
        for (int j = 1; j <= BACK; j++) begin
            e.cyc = bk_start + HOME_P * j;
            e.dir = 1'b1;
            e.pos = (j == BACK) ? 0 : -15 + j;
            exp_q.push_back(e);
        end
        exp_pos = 0;
        check("home_fault_cleared", fault, 0);
        wait_idle("home_idle", 2000);
        check("home_homed", homed, 1);
        check("home_pos", longint'(position), 0);
        check("home_done_cnt", done_cnt, 4);
        check("home_done_cyc", done_cyc, bk_start + HOME_P * BACK);
        check("home_queue", exp_q.size(), 0);
        limit_raw = 1'b0;
        repeat (DB + 4) @(negedge osc_clk);

        // Stop after 3 of 10 steps.
        issue(1'b0, 1'b1, 10, 20, acc);
        push_steps(acc, 20, 3, 1'b1);
        wait_pulses("stop_three_pulses", 3, 100);
        stop = 1'b1;
        @(negedge osc_clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        repeat (30) @(negedge osc_clk);
        check("stop_pos", longint'(position), 3);
        check("stop_fault", fault, 0);
        check("stop_done_cnt", done_cnt, 4);
        check("stop_homed", homed, 1);
        check("stop_queue", exp_q.size(), 0);

        // Zero-length move: done the cycle after accept, no strobes.
        pc = pulse_cnt;
        issue(1'b0, 1'b1, 0, 20, acc);
        @(negedge osc_clk);
        check("zero_done_cnt", done_cnt, 5);
        check("zero_done_cyc", done_cyc, acc);
        check("zero_busy", busy, 0);
        repeat (30) @(negedge osc_clk);
        check("zero_pulses", pulse_cnt, pc);

`ifdef AXIS_SOFT_LIMIT_EN
        // Return to 0, then overshoot the soft upper bound.
        issue(1'b0, 1'b0, 3, 16, acc);
        push_steps(acc, 16, 3, 1'b0);
        wait_idle("soft_ret_idle", 200);
        check("soft_ret_pos", longint'(position), 0);
        check("soft_ret_done", done_cnt, 6);
        issue(1'b0, 1'b1, 12, 16, acc);
        push_steps(acc, 16, 10, 1'b1);
        wait_idle("soft_idle", 400);
        repeat (20) @(negedge osc_clk);
        check("soft_fault", fault, 1);
        check("soft_pos", longint'(position), 10);
        check("soft_done_cnt", done_cnt, 6);
        check("soft_queue", exp_q.size(), 0);
`endif

        // Reset mid-move aborts with no further strobes.
        pc = pulse_cnt;
        issue(1'b0, 1'b1, 5, 16, acc);
        push_steps(acc, 16, 1, 1'b1);
        repeat (20) @(negedge osc_clk);
        rstn = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_pos", longint'(position), 0);
        check("rstmid_pulse", step_pulse, 0);
        repeat (40) @(negedge osc_clk);
        check("rstmid_pulses", pulse_cnt, pc + 1);
        rstn = 1'b1;
        repeat (40) @(negedge osc_clk);
        check("rstmid_no_resume", pulse_cnt, pc + 1);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
